// File: rtl/tx_arb.sv
// tx_arb: two-requester transmit arbiter in front of a UART transmitter.
//
// Each requester has a one-word holding slot. A slot is granted to the UART
// with round-robin on ties. The word is strobed once, then the arbiter waits
// for the UART busy handshake (rise, then fall) before it frees the slot.
// If busy never rises within BUSY_TO cycles, the arbiter flags an error and
// re-arbitrates with the slot still full, so the word is retried.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   i_req_valid  one-cycle write pulse per requester (0 = sequencer, 1 = send path)
//   i_req_data0  requester 0 word
//   i_req_data1  requester 1 word
//   o_req_full   slot r holds an unsent word
//   o_ovf        sticky: a write arrived while its slot was full (write dropped)
//   i_tx_busy    UART transmitter busy
//   o_tx_data    word to the UART (0 while idle)
//   o_tx_stb     one-cycle UART transmit strobe
//   o_err        sticky: busy did not rise within BUSY_TO cycles of a strobe
//   o_sent_cnt   completed-word count, wraps 255 -> 0
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no transfer; grant a full slot if any
// STROBE      | o_tx_stb high for this single cycle
// WAIT_BUSY   | waiting for UART busy to rise, bounded by BUSY_TO cycles
// WAIT_DONE   | UART busy; on busy fall the granted slot is freed

module tx_arb #(
  parameter int DW      = 16,
  parameter int BUSY_TO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    i_req_valid,
  input  logic [DW-1:0] i_req_data0,
  input  logic [DW-1:0] i_req_data1,
  output logic [1:0]    o_req_full,
  output logic [1:0]    o_ovf,
  input  logic          i_tx_busy,
  output logic [DW-1:0] o_tx_data,
  output logic          o_tx_stb,
  output logic          o_err,
  output logic [7:0]    o_sent_cnt
);

  localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_STROBE    = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic          gnt;
  logic          last_gnt;
  logic [TW-1:0] timer;
  logic [1:0]    slot_full;
  logic [DW-1:0] slot_data0;
  logic [DW-1:0] slot_data1;
  logic [1:0]    ovf;
  logic          err;
  logic [7:0]    sent_cnt;

  logic          done;
  logic [1:0]    clr;
  logic [1:0]    wr_ok;
  logic [1:0]    drop;
  logic          pick;

  // Transfer completes on busy fall while in WAIT_DONE.
  assign done = (state == S_WAIT_DONE) && !i_tx_busy;
  assign clr  = {done & gnt, done & ~gnt};

  // A slot being freed this cycle can take a new word in the same cycle.
  assign wr_ok = i_req_valid & (~slot_full | clr);
  assign drop  = i_req_valid & slot_full & ~clr;

  // Single full slot wins outright; on a tie, the one not granted last wins.
  always_comb begin
    pick = 1'b0;
    case (slot_full)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_gnt;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_full  <= 2'b00;
      slot_data0 <= '0;
      slot_data1 <= '0;
      ovf        <= 2'b00;
    end else begin
      slot_full <= wr_ok | (slot_full & ~clr);
      ovf       <= ovf | drop;
      if (wr_ok[0]) slot_data0 <= i_req_data0;
      if (wr_ok[1]) slot_data1 <= i_req_data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      timer    <= '0;
      err      <= 1'b0;
      sent_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|slot_full) begin
            gnt   <= pick;
            state <= S_STROBE;
          end
        end
        S_STROBE: begin
          timer <= TW'(BUSY_TO - 1);
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == '0) begin
            // Slot stays full: the word is retried through normal arbitration.
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            state    <= S_IDLE;
            sent_cnt <= sent_cnt + 8'd1;
            last_gnt <= gnt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The granted slot cannot be overwritten while full, so the word is stable
  // from the strobe through the busy fall.
  assign o_tx_data  = (state == S_IDLE) ? '0 : (gnt ? slot_data1 : slot_data0);
  assign o_tx_stb   = (state == S_STROBE);
  assign o_req_full = slot_full;
  assign o_ovf      = ovf;
  assign o_err      = err;
  assign o_sent_cnt = sent_cnt;

endmodule

// File: tb/tb_tx_arb.sv
// Randomized and directed bench for tx_arb against a behavioural model.

module tb_tx_arb;

  localparam int DW      = 16;
  localparam int BUSY_TO = 16;

  localparam int P_IDLE = 0;
  localparam int P_STB  = 1;
  localparam int P_WB   = 2;
  localparam int P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
  logic          busy = 1'b0;
  logic [1:0]    o_req_full;
  logic [1:0]    o_ovf;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_stb;
  logic          o_err;
  logic [7:0]    o_sent_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: slot contents, flags, and which phase of the
  // strobe / busy-rise / busy-fall handshake the arbiter is in.
  logic [1:0]    m_full;
  logic [DW-1:0] m_data [2];
  logic [1:0]    m_ovf;
  logic          m_err;
  int            m_cnt;
  logic          m_last;
  logic          m_gnt;
  int            m_phase;
  int            m_wait;

  logic [DW-1:0] seen [$];

  tx_arb #(.DW(DW), .BUSY_TO(BUSY_TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data0 (d0),
    .i_req_data1 (d1),
    .o_req_full  (o_req_full),
    .o_ovf       (o_ovf),
    .i_tx_busy   (busy),
    .o_tx_data   (o_tx_data),
    .o_tx_stb    (o_tx_stb),
    .o_err       (o_err),
    .o_sent_cnt  (o_sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = 2'b00;
    m_data[0] = '0;
    m_data[1] = '0;
    m_ovf   = 2'b00;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_last  = 1'b1;
    m_gnt   = 1'b0;
    m_phase = P_IDLE;
    m_wait  = 0;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_cnt;
    exp_data = (m_phase == P_IDLE) ? '0 : m_data[m_gnt];
    exp_cnt  = 8'(m_cnt);
    chk("req_full", 32'(o_req_full), 32'(m_full));
    chk("ovf",      32'(o_ovf),      32'(m_ovf));
    chk("err",      32'(o_err),      32'(m_err));
    chk("sent_cnt", 32'(o_sent_cnt), 32'(exp_cnt));
    chk("tx_stb",   32'(o_tx_stb),   32'(m_phase == P_STB));
    chk("tx_data",  32'(o_tx_data),  32'(exp_data));
    if (o_tx_stb === 1'b1) seen.push_back(o_tx_data);
  endtask

  // Advance the model by one clock edge given the inputs presented to it.
  task automatic model_update(input logic [1:0] v, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic bz);
    logic [1:0] old_full;
    logic       fin;
    old_full = m_full;
    fin      = (m_phase == P_DONE) && !bz;
    if (fin) begin
      m_full[m_gnt] = 1'b0;
      m_cnt  = (m_cnt + 1) % 256;
      m_last = m_gnt;
    end
    for (int r = 0; r < 2; r++) begin
      if (v[r]) begin
        if (m_full[r]) m_ovf[r] = 1'b1;
        else begin
          m_full[r] = 1'b1;
          m_data[r] = (r == 1) ? b : a;
        end
      end
    end
    case (m_phase)
      P_IDLE: if (old_full != 2'b00) begin
        m_gnt   = (old_full == 2'b11) ? ~m_last : old_full[1];
        m_phase = P_STB;
      end
      P_STB: begin
        m_phase = P_WB;
        m_wait  = 0;
      end
      P_WB: begin
        if (bz) m_phase = P_DONE;
        else begin
          m_wait++;
          if (m_wait == BUSY_TO) begin
            m_phase = P_IDLE;
            m_err   = 1'b1;
          end
        end
      end
      default: if (!bz) m_phase = P_IDLE;
    endcase
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, check.
  task automatic step(input logic [1:0] v, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic bz);
    req_valid = v;
    d0        = a;
    d1        = b;
    busy      = bz;
    model_update(v, a, b, bz);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    busy      = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outputs();
    seen.delete();
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (m_phase != P_STB && n < 40) begin
      step(2'b00, '0, '0, 1'b0);
      n++;
    end
    chk("strobe_wait", 32'(o_tx_stb), 32'd1);
  endtask

  task automatic run_uart(input int dly, input int len);
    int n = 0;
    wait_strobe();
    repeat (dly) step(2'b00, '0, '0, 1'b0);
    repeat (len) step(2'b00, '0, '0, 1'b1);
    while (m_phase != P_IDLE && n < 40) begin
      step(2'b00, '0, '0, 1'b0);
      n++;
    end
    chk("done_wait", 32'(n < 40), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nseen;
    int r_dly;
    int r_len;
    bit r_act;
    logic bz;

    // Single word with a late, long busy pulse.
    do_reset();
    step(2'b01, 16'hA5C3, '0, 1'b0);
    run_uart(3, 20);
    chk("t1_nstb", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("t1_data", 32'(seen[0]), 32'hA5C3);
    chk("t1_cnt",  32'(o_sent_cnt), 32'd1);
    chk("t1_full", 32'(o_req_full), 32'd0);

    // Tie goes to requester 0 first, then round-robin.
    do_reset();
    step(2'b11, 16'h1111, 16'h2222, 1'b0);
    run_uart(1, 2);
    step(2'b01, 16'h3333, '0, 1'b0);
    run_uart(2, 1);
    run_uart(0, 3);
    chk("t2_nstb", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("t2_w0", 32'(seen[0]), 32'h1111);
      chk("t2_w1", 32'(seen[1]), 32'h2222);
      chk("t2_w2", 32'(seen[2]), 32'h3333);
    end

    // Overflow on requester 1 while its word is in flight.
    do_reset();
    step(2'b10, '0, 16'hBEEF, 1'b0);
    step(2'b00, '0, '0, 1'b0);
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b1);
    step(2'b10, '0, 16'hDEAD, 1'b1);
    step(2'b00, '0, '0, 1'b0);
    repeat (4) step(2'b00, '0, '0, 1'b0);
    chk("t3_ovf",  32'(o_ovf), 32'h2);
    chk("t3_nstb", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("t3_data", 32'(seen[0]), 32'hBEEF);

    // Busy never rises: timeout, error, retry of the same word.
    do_reset();
    step(2'b01, 16'h7E57, '0, 1'b0);
    repeat (2 + BUSY_TO) step(2'b00, '0, '0, 1'b0);
    chk("t4_err",  32'(o_err), 32'd1);
    chk("t4_cnt",  32'(o_sent_cnt), 32'd0);
    chk("t4_full", 32'(o_req_full), 32'd1);
    step(2'b00, '0, '0, 1'b0);
    run_uart(1, 2);
    chk("t4_nstb", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("t4_w0", 32'(seen[0]), 32'h7E57);
      chk("t4_w1", 32'(seen[1]), 32'h7E57);
    end
    chk("t4_cnt2", 32'(o_sent_cnt), 32'd1);

    // Write coinciding with the busy fall, repeated 256 times for the wrap.
    do_reset();
    step(2'b01, 16'h1000, '0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      wait_strobe();
      step(2'b00, '0, '0, 1'b1);
      step(2'b00, '0, '0, 1'b1);
      if (k < 255) step(2'b01, 16'(16'h1000 + k + 1), '0, 1'b0);
      else         step(2'b00, '0, '0, 1'b0);
      if (k < 255) chk("t5_keep_full", 32'(o_req_full), 32'd1);
      if (k == 254) chk("t5_cnt255", 32'(o_sent_cnt), 32'd255);
    end
    chk("t5_wrap", 32'(o_sent_cnt), 32'd0);
    chk("t5_nstb", 32'(seen.size()), 32'd256);
    if (seen.size() == 256) begin
      chk("t5_first", 32'(seen[0]),   32'h1000);
      chk("t5_mid",   32'(seen[128]), 32'h1080);
      chk("t5_last",  32'(seen[255]), 32'h10FF);
    end

    // Reset while the UART is busy with a word.
    do_reset();
    step(2'b01, 16'h5A5A, '0, 1'b0);
    step(2'b00, '0, '0, 1'b0);
    step(2'b00, '0, '0, 1'b1);
    step(2'b00, '0, '0, 1'b1);
    chk("t6_indone", 32'(o_tx_data), 32'h5A5A);
    nseen = seen.size();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_data", 32'(o_tx_data), 32'd0);
    chk("t6_rst_full", 32'(o_req_full), 32'd0);
    check_outputs();
    busy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(2'b00, '0, '0, 1'(i < 4));
    chk("t6_nostb", 32'(seen.size()), 32'(nseen));

    // Randomized traffic with a UART responder that sometimes never answers.
    do_reset();
    r_act = 1'b0;
    r_dly = 0;
    r_len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_phase == P_STB) begin
        r_act = 1'b1;
        r_dly = ($urandom_range(0, 19) == 0) ? BUSY_TO + 2 : int'($urandom_range(0, 4));
        r_len = $urandom_range(1, 6);
      end
      bz = 1'b0;
      if (r_act) begin
        if (r_dly > 0) r_dly--;
        else if (r_len > 0) begin
          bz = 1'b1;
          r_len--;
        end else r_act = 1'b0;
      end
      step({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
           16'($urandom), 16'($urandom), bz);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
